// File: rtl/pcie_fc_pkg.sv
// Shared constants and types for the PCIe flow-control selection poller.
package pcie_fc_pkg;

  localparam int FC_HDR_W  = 8;
  localparam int FC_DATA_W = 12;

  localparam logic [2:0] FC_SEL_RX_AVAIL = 3'd0;
  localparam logic [2:0] FC_SEL_RX_LIMIT = 3'd1;
  localparam logic [2:0] FC_SEL_RX_CONS  = 3'd2;
  localparam logic [2:0] FC_SEL_TX_AVAIL = 3'd4;
  localparam logic [2:0] FC_SEL_TX_LIMIT = 3'd5;
  localparam logic [2:0] FC_SEL_TX_CONS  = 3'd6;

  typedef struct packed {
    logic [FC_HDR_W-1:0]  ph;
    logic [FC_DATA_W-1:0] pd;
    logic [FC_HDR_W-1:0]  nph;
    logic [FC_DATA_W-1:0] npd;
    logic [FC_HDR_W-1:0]  cplh;
    logic [FC_DATA_W-1:0] cpld;
  } fc_credits_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } poll_state_t;

endpackage

// File: rtl/fc_sel_rr_next.sv
// Rotate-priority search: first set bit of mask strictly after cur, wrapping
// around modulo 8 (cur itself is the last candidate).
module fc_sel_rr_next (
  input  logic [7:0] mask,
  input  logic [2:0] cur,
  output logic [2:0] next,
  output logic       found
);

  logic [7:0] rot_mask;
  logic [2:0] offset;

  // rot_mask[i] corresponds to index cur+1+i
  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    assign rot_mask[gi] = mask[3'(cur + 3'(gi + 1))];
  end

  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (rot_mask[i]) begin
        offset = 3'(i);
        found  = 1'b1;
      end
    end
  end

  assign next = cur + 3'd1 + offset;

endmodule

// File: rtl/pcie_fc_sel_poller.sv
// Round-robin poller of the PCIe hard-IP flow-control selection pins; publishes
// tagged samples and holds the latest TX-available credit set.
module pcie_fc_sel_poller
  import pcie_fc_pkg::*;
#(
  parameter logic [7:0]  SEL_ENABLE_MASK = 8'b0111_0000,
  parameter int unsigned FC_SEL_LATENCY  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [2:0]           cfg_fc_sel,
  input  logic [FC_HDR_W-1:0]  cfg_fc_ph,
  input  logic [FC_DATA_W-1:0] cfg_fc_pd,
  input  logic [FC_HDR_W-1:0]  cfg_fc_nph,
  input  logic [FC_DATA_W-1:0] cfg_fc_npd,
  input  logic [FC_HDR_W-1:0]  cfg_fc_cplh,
  input  logic [FC_DATA_W-1:0] cfg_fc_cpld,
  output logic                 sample_valid,
  output logic [2:0]           sample_sel,
  output logic [FC_HDR_W-1:0]  sample_ph,
  output logic [FC_DATA_W-1:0] sample_pd,
  output logic [FC_HDR_W-1:0]  sample_nph,
  output logic [FC_DATA_W-1:0] sample_npd,
  output logic [FC_HDR_W-1:0]  sample_cplh,
  output logic [FC_DATA_W-1:0] sample_cpld,
  output logic                 tx_avail_valid,
  output logic [FC_HDR_W-1:0]  tx_avail_ph,
  output logic [FC_DATA_W-1:0] tx_avail_pd,
  output logic [FC_HDR_W-1:0]  tx_avail_nph,
  output logic [FC_DATA_W-1:0] tx_avail_npd,
  output logic [FC_HDR_W-1:0]  tx_avail_cplh,
  output logic [FC_DATA_W-1:0] tx_avail_cpld
);

  localparam logic [3:0] LAT = 4'(FC_SEL_LATENCY);

  poll_state_t state_reg, state_next;
  logic [2:0]  sel_reg, sel_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        capture;
  logic [2:0]  rr_cur, rr_next;
  logic        rr_found;

  logic        sample_valid_reg;
  logic [2:0]  sample_sel_reg;
  fc_credits_t sample_reg;
  fc_credits_t tx_reg;
  logic        tx_valid_reg;
  fc_credits_t fc_in;

  assign fc_in = '{ph: cfg_fc_ph, pd: cfg_fc_pd, nph: cfg_fc_nph,
                   npd: cfg_fc_npd, cplh: cfg_fc_cplh, cpld: cfg_fc_cpld};

  // Searching from index 7 yields the lowest enabled index, so one search
  // unit serves both the initial load and the per-slot advance.
  assign rr_cur = (state_reg == ST_IDLE) ? 3'd7 : sel_reg;

  fc_sel_rr_next u_rr (
    .mask  (SEL_ENABLE_MASK),
    .cur   (rr_cur),
    .next  (rr_next),
    .found (rr_found)
  );

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // An empty mask never finds an index, so polling never starts.
        if (rr_found) begin
          sel_next   = rr_next;
          cnt_next   = LAT;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) begin
          capture  = 1'b1;
          sel_next = rr_next;
          cnt_next = LAT;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      sel_reg          <= '0;
      cnt_reg          <= '0;
      sample_valid_reg <= 1'b0;
      sample_sel_reg   <= '0;
      sample_reg       <= '0;
      tx_reg           <= '0;
      tx_valid_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sel_reg          <= sel_next;
      cnt_reg          <= cnt_next;
      sample_valid_reg <= capture;
      if (capture) begin
        sample_sel_reg <= sel_reg;
        sample_reg     <= fc_in;
        if (sel_reg == FC_SEL_TX_AVAIL) begin
          tx_reg       <= fc_in;
          tx_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign cfg_fc_sel     = sel_reg;
  assign sample_valid   = sample_valid_reg;
  assign sample_sel     = sample_sel_reg;
  assign sample_ph      = sample_reg.ph;
  assign sample_pd      = sample_reg.pd;
  assign sample_nph     = sample_reg.nph;
  assign sample_npd     = sample_reg.npd;
  assign sample_cplh    = sample_reg.cplh;
  assign sample_cpld    = sample_reg.cpld;
  assign tx_avail_valid = tx_valid_reg;
  assign tx_avail_ph    = tx_reg.ph;
  assign tx_avail_pd    = tx_reg.pd;
  assign tx_avail_nph   = tx_reg.nph;
  assign tx_avail_npd   = tx_reg.npd;
  assign tx_avail_cplh  = tx_reg.cplh;
  assign tx_avail_cpld  = tx_reg.cpld;

endmodule

// File: tb/tb_pcie_fc_sel_poller.sv
// Bench for pcie_fc_sel_poller: four parameterisations fed by a delayed-selection
// IP model, checked against slot arithmetic derived from the enable mask.
module tb_pcie_fc_sel_poller;
  import pcie_fc_pkg::*;

  localparam logic [7:0] MASK_DEF = 8'b0111_0000;
  localparam logic [7:0] MASK_ONE = 8'b0001_0000;
  localparam logic [7:0] MASK_ZERO = 8'b0000_0000;
  localparam logic [7:0] MASK_L0 = 8'b1000_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] pd4 = 12'h0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // d: default, o: single enabled bit, z: empty mask, l: zero latency
  logic [2:0] d_sel, o_sel, z_sel, l_sel;
  logic [2:0] d_d1 = 3'd0, d_d2 = 3'd0, o_d1 = 3'd0, o_d2 = 3'd0, z_d1 = 3'd0, z_d2 = 3'd0;
  fc_credits_t d_in, o_in, z_in, l_in;
  logic d_sv, o_sv, z_sv, l_sv, d_tv, o_tv, z_tv, l_tv;
  logic [2:0] d_ss, o_ss, z_ss, l_ss;
  fc_credits_t d_samp, o_samp, z_samp, l_samp, d_tx, o_tx, z_tx, l_tx;

  // IP model: credits are a fixed function of the selection seen FC_SEL_LATENCY cycles ago
  function automatic fc_credits_t ip_model(input logic [2:0] sel, input logic [11:0] p4);
    fc_credits_t r;
    r.ph   = 8'h10 + 8'(sel);
    r.pd   = (sel == 3'd4) ? p4 : 12'h200 + 12'(sel);
    r.nph  = 8'h20 + 8'(sel);
    r.npd  = 12'h300 + 12'(sel);
    r.cplh = 8'h30 + 8'(sel);
    r.cpld = 12'h400 + 12'(sel);
    return r;
  endfunction

  always @(posedge clk) begin
    d_d1 <= d_sel; d_d2 <= d_d1;
    o_d1 <= o_sel; o_d2 <= o_d1;
    z_d1 <= z_sel; z_d2 <= z_d1;
  end
  always_comb d_in = ip_model(d_d2, pd4);
  always_comb o_in = ip_model(o_d2, pd4);
  always_comb z_in = ip_model(z_d2, pd4);
  always_comb l_in = ip_model(l_sel, pd4);

  pcie_fc_sel_poller #(.SEL_ENABLE_MASK(MASK_DEF), .FC_SEL_LATENCY(2)) u_def (
    .clk(clk), .rst(rst), .cfg_fc_sel(d_sel),
    .cfg_fc_ph(d_in.ph), .cfg_fc_pd(d_in.pd), .cfg_fc_nph(d_in.nph),
    .cfg_fc_npd(d_in.npd), .cfg_fc_cplh(d_in.cplh), .cfg_fc_cpld(d_in.cpld),
    .sample_valid(d_sv), .sample_sel(d_ss),
    .sample_ph(d_samp.ph), .sample_pd(d_samp.pd), .sample_nph(d_samp.nph),
    .sample_npd(d_samp.npd), .sample_cplh(d_samp.cplh), .sample_cpld(d_samp.cpld),
    .tx_avail_valid(d_tv),
    .tx_avail_ph(d_tx.ph), .tx_avail_pd(d_tx.pd), .tx_avail_nph(d_tx.nph),
    .tx_avail_npd(d_tx.npd), .tx_avail_cplh(d_tx.cplh), .tx_avail_cpld(d_tx.cpld));

  pcie_fc_sel_poller #(.SEL_ENABLE_MASK(MASK_ONE), .FC_SEL_LATENCY(2)) u_one (
    .clk(clk), .rst(rst), .cfg_fc_sel(o_sel),
    .cfg_fc_ph(o_in.ph), .cfg_fc_pd(o_in.pd), .cfg_fc_nph(o_in.nph),
    .cfg_fc_npd(o_in.npd), .cfg_fc_cplh(o_in.cplh), .cfg_fc_cpld(o_in.cpld),
    .sample_valid(o_sv), .sample_sel(o_ss),
    .sample_ph(o_samp.ph), .sample_pd(o_samp.pd), .sample_nph(o_samp.nph),
    .sample_npd(o_samp.npd), .sample_cplh(o_samp.cplh), .sample_cpld(o_samp.cpld),
    .tx_avail_valid(o_tv),
    .tx_avail_ph(o_tx.ph), .tx_avail_pd(o_tx.pd), .tx_avail_nph(o_tx.nph),
    .tx_avail_npd(o_tx.npd), .tx_avail_cplh(o_tx.cplh), .tx_avail_cpld(o_tx.cpld));

  pcie_fc_sel_poller #(.SEL_ENABLE_MASK(MASK_ZERO), .FC_SEL_LATENCY(2)) u_zero (
    .clk(clk), .rst(rst), .cfg_fc_sel(z_sel),
    .cfg_fc_ph(z_in.ph), .cfg_fc_pd(z_in.pd), .cfg_fc_nph(z_in.nph),
    .cfg_fc_npd(z_in.npd), .cfg_fc_cplh(z_in.cplh), .cfg_fc_cpld(z_in.cpld),
    .sample_valid(z_sv), .sample_sel(z_ss),
    .sample_ph(z_samp.ph), .sample_pd(z_samp.pd), .sample_nph(z_samp.nph),
    .sample_npd(z_samp.npd), .sample_cplh(z_samp.cplh), .sample_cpld(z_samp.cpld),
    .tx_avail_valid(z_tv),
    .tx_avail_ph(z_tx.ph), .tx_avail_pd(z_tx.pd), .tx_avail_nph(z_tx.nph),
    .tx_avail_npd(z_tx.npd), .tx_avail_cplh(z_tx.cplh), .tx_avail_cpld(z_tx.cpld));

  pcie_fc_sel_poller #(.SEL_ENABLE_MASK(MASK_L0), .FC_SEL_LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .cfg_fc_sel(l_sel),
    .cfg_fc_ph(l_in.ph), .cfg_fc_pd(l_in.pd), .cfg_fc_nph(l_in.nph),
    .cfg_fc_npd(l_in.npd), .cfg_fc_cplh(l_in.cplh), .cfg_fc_cpld(l_in.cpld),
    .sample_valid(l_sv), .sample_sel(l_ss),
    .sample_ph(l_samp.ph), .sample_pd(l_samp.pd), .sample_nph(l_samp.nph),
    .sample_npd(l_samp.npd), .sample_cplh(l_samp.cplh), .sample_cpld(l_samp.cpld),
    .tx_avail_valid(l_tv),
    .tx_avail_ph(l_tx.ph), .tx_avail_pd(l_tx.pd), .tx_avail_nph(l_tx.nph),
    .tx_avail_npd(l_tx.npd), .tx_avail_cplh(l_tx.cplh), .tx_avail_cpld(l_tx.cpld));

  // k-th selection of the polling order (enabled indices ascending, repeating)
  function automatic logic [2:0] nth_en(input logic [7:0] mask, input int k);
    int list[$];
    for (int i = 0; i < 8; i++) if (mask[i]) list.push_back(i);
    return 3'(list[k % list.size()]);
  endfunction

  // Leaves the bench at a falling edge with rst low; the next rising edge is
  // the first one out of reset (edge m=0 in the tests below).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({d_sel, o_sel, z_sel, l_sel} !== 12'h0) begin
      n_fail++; $display("FAIL reset_sel got %h want 000", {d_sel, o_sel, z_sel, l_sel});
    end
    n_tests++;
    if ({d_sv, o_sv, z_sv, l_sv, d_tv, o_tv, z_tv, l_tv} !== 8'h0) begin
      n_fail++; $display("FAIL reset_valid got %b want 0", {d_sv, o_sv, z_sv, l_sv, d_tv, o_tv, z_tv, l_tv});
    end
    n_tests++;
    if (d_samp !== '0 || d_tx !== '0 || d_ss !== 3'd0 || l_samp !== '0) begin
      n_fail++; $display("FAIL reset_data got samp=%h tx=%h ss=%0d want 0", d_samp, d_tx, d_ss);
    end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int c, ncyc;
    logic [2:0] s;
    pd4 = 12'($urandom_range(0, 4095));
    do_reset();
    ncyc = 36 + int'($urandom_range(0, 5));
    for (int m = 0; m < ncyc; m++) begin
      @(posedge clk); @(negedge clk);
      c = m / 3;
      n_tests++;
      if (d_sel !== nth_en(MASK_DEF, c)) begin
        n_fail++; $display("FAIL rr_sel m=%0d got %0d want %0d", m, d_sel, nth_en(MASK_DEF, c));
      end
      n_tests++;
      if (d_sv !== (m > 0 && m % 3 == 0)) begin
        n_fail++; $display("FAIL rr_valid m=%0d got %b want %b", m, d_sv, (m > 0 && m % 3 == 0));
      end
      if (c > 0) begin
        s = nth_en(MASK_DEF, c - 1);
        n_tests++;
        if (d_ss !== s || d_samp !== ip_model(s, pd4)) begin
          n_fail++; $display("FAIL rr_sample m=%0d got sel=%0d data=%h want sel=%0d data=%h",
                             m, d_ss, d_samp, s, ip_model(s, pd4));
        end
      end
    end
  endtask

  task automatic test_tx_avail();
    logic [11:0] pd_a, pd_b, pd_at_edge, exp_pd;
    logic exp_tv;
    int c;
    pd_a = 12'($urandom_range(0, 4095));
    pd_b = pd_a ^ 12'($urandom_range(1, 4095));
    pd4 = pd_a;
    exp_tv = 1'b0;
    exp_pd = 12'h0;
    do_reset();
    for (int m = 0; m < 30; m++) begin
      pd_at_edge = pd4;
      @(posedge clk); @(negedge clk);
      c = m / 3;
      if (m > 0 && m % 3 == 0 && nth_en(MASK_DEF, c - 1) == FC_SEL_TX_AVAIL) begin
        exp_tv = 1'b1;
        exp_pd = pd_at_edge;
      end
      n_tests++;
      if (d_tv !== exp_tv) begin
        n_fail++; $display("FAIL tx_valid m=%0d got %b want %b", m, d_tv, exp_tv);
      end
      n_tests++;
      if (d_tx.ph !== (exp_tv ? 8'h14 : 8'h0) || d_tx.pd !== exp_pd ||
          d_tx.cplh !== (exp_tv ? 8'h34 : 8'h0)) begin
        n_fail++; $display("FAIL tx_data m=%0d got ph=%h pd=%h cplh=%h want ph=%h pd=%h",
                           m, d_tx.ph, d_tx.pd, d_tx.cplh, exp_tv ? 8'h14 : 8'h0, exp_pd);
      end
      // switch the sel=4 data right after the sel=5 sample of the second round
      if (m == 15) pd4 = pd_b;
    end
  endtask

  task automatic test_single_sel();
    int c;
    do_reset();
    for (int m = 0; m < 24; m++) begin
      @(posedge clk); @(negedge clk);
      c = m / 3;
      n_tests++;
      if (o_sel !== 3'd4 || o_sv !== (m > 0 && m % 3 == 0)) begin
        n_fail++; $display("FAIL single_sel m=%0d got sel=%0d valid=%b want sel=4 valid=%b",
                           m, o_sel, o_sv, (m > 0 && m % 3 == 0));
      end
      if (c > 0) begin
        n_tests++;
        if (o_ss !== 3'd4 || o_samp.ph !== 8'h14) begin
          n_fail++; $display("FAIL single_sample m=%0d got sel=%0d ph=%h want sel=4 ph=14", m, o_ss, o_samp.ph);
        end
      end
    end
  endtask

  task automatic test_mask_zero();
    do_reset();
    for (int m = 0; m < 100; m++) begin
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (z_sel !== 3'd0 || z_sv !== 1'b0 || z_tv !== 1'b0) begin
        n_fail++; $display("FAIL mask_zero m=%0d got sel=%0d valid=%b tx_valid=%b want 0 0 0", m, z_sel, z_sv, z_tv);
      end
    end
  endtask

  task automatic test_reset_mid_slot();
    int target;
    // a sel=5 slot, at the cycle where its counter reads 1
    target = (1 + 3 * int'($urandom_range(0, 2))) * 3 + 1;
    do_reset();
    for (int m = 0; m <= target; m++) begin
      @(posedge clk); @(negedge clk);
    end
    n_tests++;
    if (d_sel !== 3'd5) begin
      n_fail++; $display("FAIL midrst_pre got sel=%0d want 5", d_sel);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tests++;
    if (d_sel !== 3'd0 || d_sv !== 1'b0 || d_ss !== 3'd0 || d_samp !== '0 || d_tx !== '0 || d_tv !== 1'b0) begin
      n_fail++; $display("FAIL midrst_zero got sel=%0d valid=%b ss=%0d samp=%h tx=%h tv=%b want all 0",
                         d_sel, d_sv, d_ss, d_samp, d_tx, d_tv);
    end
    rst = 1'b0;
    for (int m = 0; m < 7; m++) begin
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (d_sel !== nth_en(MASK_DEF, m / 3) || d_sv !== (m > 0 && m % 3 == 0)) begin
        n_fail++; $display("FAIL midrst_restart m=%0d got sel=%0d valid=%b want sel=%0d valid=%b",
                           m, d_sel, d_sv, nth_en(MASK_DEF, m / 3), (m > 0 && m % 3 == 0));
      end
    end
  endtask

  task automatic test_latency0();
    logic [2:0] s;
    do_reset();
    for (int m = 0; m < 20; m++) begin
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (l_sel !== nth_en(MASK_L0, m) || l_sv !== (m > 0)) begin
        n_fail++; $display("FAIL lat0_sel m=%0d got sel=%0d valid=%b want sel=%0d valid=%b",
                           m, l_sel, l_sv, nth_en(MASK_L0, m), (m > 0));
      end
      if (m > 0) begin
        s = nth_en(MASK_L0, m - 1);
        n_tests++;
        if (l_ss !== s || l_samp.ph !== 8'h10 + 8'(s)) begin
          n_fail++; $display("FAIL lat0_sample m=%0d got sel=%0d ph=%h want sel=%0d ph=%h",
                             m, l_ss, l_samp.ph, s, 8'h10 + 8'(s));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_tx_avail();
    test_single_sel();
    test_mask_zero();
    test_reset_mid_slot();
    test_latency0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_fc_sel_poller.md
Name: pcie_fc_sel_poller

Overview:
- Sits between the PCIe hard-IP flow-control status pins (cfg_fc_ph/pd/nph/npd/cplh/cpld, cfg_fc_sel) and the DMA bench core.
- Time-multiplexes cfg_fc_sel round-robin over a configurable set of credit selections.
- Waits the IP's selection-to-data latency, then captures the credit counts.
- Publishes each capture as a tagged one-cycle sample, and keeps a held copy of the transmit-credits-available set that the DMA core's read/write flow control consumes.

Parameters:
- SEL_ENABLE_MASK, 8'b0111_0000: bit n set means cfg_fc_sel value n is polled. Default polls 4 (TX available), 5 (TX limit) and 6 (TX consumed).
- FC_SEL_LATENCY, 2: number of cycles after a cfg_fc_sel change before cfg_fc_* reflect the new selection. Allowed range 0..15.

Ports:
- clk  in  1  clock, sole clock domain
- rst  in  1  reset, synchronous, active-high
- cfg_fc_sel  out  3  selection driven to the PCIe IP
- cfg_fc_ph  in  8  posted header credits
- cfg_fc_pd  in  12  posted data credits
- cfg_fc_nph  in  8  non-posted header credits
- cfg_fc_npd  in  12  non-posted data credits
- cfg_fc_cplh  in  8  completion header credits
- cfg_fc_cpld  in  12  completion data credits
- sample_valid  out  1  one-cycle strobe: sample_* hold a fresh capture
- sample_sel  out  3  selection that the capture belongs to
- sample_ph/pd/nph/npd/cplh/cpld  out  8/12/8/12/8/12  captured values
- tx_avail_valid  out  1  sticky; set after the first sel=4 capture
- tx_avail_ph/pd/nph/npd/cplh/cpld  out  8/12/8/12/8/12  held sel=4 values

Behaviour:
- Reset values: cfg_fc_sel=0; all sample_* and tx_avail_* outputs=0; latency counter=0; state=IDLE. Reset asserted mid-slot aborts the slot with no sample.
- States:
  - IDLE: entered on reset exit. If SEL_ENABLE_MASK==0, stay in IDLE forever: cfg_fc_sel stays 0 and sample_valid never asserts. Otherwise, on the next edge, load cfg_fc_sel with the lowest enabled index, load the counter with FC_SEL_LATENCY, and go to WAIT.
  - WAIT: the counter decrements each cycle. In the cycle where counter==0, capture at that edge:
    - all six cfg_fc_* inputs go into sample_*;
    - cfg_fc_sel goes into sample_sel;
    - sample_valid=1 for exactly the following cycle;
    - cfg_fc_sel advances to the next enabled index above the current one, wrapping to the lowest enabled index;
    - the counter reloads with FC_SEL_LATENCY;
    - state remains WAIT.
- Slot length is FC_SEL_LATENCY+1 cycles. cfg_fc_sel is stable for the whole slot. Captures are back-to-back with no idle cycles.
- Single enabled bit: cfg_fc_sel never changes after IDLE, and a sample is still produced every FC_SEL_LATENCY+1 cycles.
- FC_SEL_LATENCY=0: capture occurs in the first cycle of the slot, giving sample_valid every cycle once polling starts.
- tx_avail_*: updated on the same edge as a capture whose sel==4, otherwise held. tx_avail_valid is set on the first such update and cleared only by rst.
- sample_* hold their last values while sample_valid=0.
- No backpressure: consumers must accept sample_valid whenever it asserts.
- Next-index search: pure combinational priority rotate over the 8-bit mask starting at current+1, modulo 8.

Decomposition:
- Shared package pcie_fc_pkg:
  - FC_SEL_RX_AVAIL=0, FC_SEL_RX_LIMIT=1, FC_SEL_RX_CONS=2, FC_SEL_TX_AVAIL=4, FC_SEL_TX_LIMIT=5, FC_SEL_TX_CONS=6;
  - width constants FC_HDR_W=8, FC_DATA_W=12;
  - a struct/typedef bundling the six credit fields.
- One sub-module is natural: fc_sel_rr_next. It takes mask and current index and returns the next enabled index (combinational, 8-way rotate-priority).

Test Plan:
- Default params, IP model with 2-cycle sel latency driving ph=0x10+sel: cfg_fc_sel sequence after reset is 4,5,6,4,..., each held 3 cycles; sample_valid every 3rd cycle; sample_sel/ph pairs (4,0x14), (5,0x15), (6,0x16); no mismatched data.
- Same stimulus: tx_avail_valid rises with the first sel=4 sample; tx_avail_ph=0x14 and is held through the 5 and 6 samples. Changing the model so pd=0x123 at sel 4 updates tx_avail_pd only on the next sel=4 capture.
- SEL_ENABLE_MASK=8'b0001_0000: cfg_fc_sel stays 4 permanently; a sample every 3 cycles, all with sample_sel=4.
- SEL_ENABLE_MASK=0: over 100 cycles cfg_fc_sel=0, sample_valid=0 and tx_avail_valid=0.
- Assert rst for 1 cycle mid-slot, while sel=5 and the counter is at 1: the next cycle has all outputs 0 and no sample_valid; polling restarts at sel 4 with a full slot.
- FC_SEL_LATENCY=0, mask 8'b1000_0001: cfg_fc_sel alternates 0,7,0,7 every cycle; sample_valid stays continuously high; sample_sel tracks the previous cycle's cfg_fc_sel.
